// File: rtl/mpsoc_wb_gpio_arb_pkg.sv
// Shared types and constants for the GPIO Wishbone round-robin arbiter.
// The optional slave-ack watchdog in the top is enabled by MPSOC_WB_GPIO_ARB_TIMEOUT_EN.
package mpsoc_wb_gpio_arb_pkg;

    localparam int MAX_MASTERS = 8;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mpsoc_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, ascending with wrap.
module mpsoc_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW:0] cand_s;

    // Scan N slots starting at ptr; the first set request wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr} + (IW + 1)'(k);
            if (cand_s >= (IW + 1)'(N)) begin
                cand_s = cand_s - (IW + 1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!valid && req[cand_s[IW-1:0]]) begin
                valid    = 1'b1;
                idx      = cand_s[IW-1:0];
                gnt      = '0;
                gnt[idx] = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/mpsoc_wb_gpio_arbiter.sv
// Round-robin Wishbone arbiter sharing one GPIO slave port; ownership spans the whole cyc.
// Define MPSOC_WB_GPIO_ARB_TIMEOUT_EN to add the slave-ack watchdog (limit = TIMEOUT).
module mpsoc_wb_gpio_arbiter
    import mpsoc_wb_gpio_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                                   wb_clk_i,
    input  logic                                   wb_rst_ni,
    input  logic [NUM_MASTERS-1:0]                 wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]                 wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]                 wbm_we_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS*3-1:0]               wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]               wbm_bte_i,
    output logic [WB_DATA_WIDTH-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]                 wbm_ack_o,
    output logic [NUM_MASTERS-1:0]                 wbm_err_o,
    output logic                                   wbs_cyc_o,
    output logic                                   wbs_stb_o,
    output logic                                   wbs_we_o,
    output logic [WB_ADDR_WIDTH-1:0]               wbs_adr_o,
    output logic [WB_DATA_WIDTH-1:0]               wbs_dat_o,
    output logic [WB_DATA_WIDTH/8-1:0]             wbs_sel_o,
    output logic [2:0]                             wbs_cti_o,
    output logic [1:0]                             wbs_bte_o,
    input  logic [WB_DATA_WIDTH-1:0]               wbs_dat_i,
    input  logic                                   wbs_ack_i,
    input  logic                                   wbs_err_i,
    output logic [NUM_MASTERS-1:0]                 grant_o,
    output logic                                   busy_o
);

    localparam int N  = NUM_MASTERS;
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("mpsoc_wb_gpio_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT 1..255");
    end

    arb_state_t    state_r, state_nxt_s;
    logic [N-1:0]  grant_r, grant_nxt_s;
    logic [IW-1:0] gidx_r, gidx_nxt_s;
    logic [IW-1:0] ptr_r, ptr_nxt_s;
    logic [N-1:0]  rr_gnt_s;
    logic [IW-1:0] rr_idx_s;
    logic          rr_valid_s;
    logic          own_s;
    logic          to_hit_s;

    assign own_s     = (state_r == OWN);
    assign grant_o   = grant_r;
    assign busy_o    = own_s;
    assign wbm_dat_o = wbs_dat_i;

    mpsoc_rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req   (wbm_cyc_i),
        .ptr   (ptr_r),
        .gnt   (rr_gnt_s),
        .idx   (rr_idx_s),
        .valid (rr_valid_s)
    );

`ifdef MPSOC_WB_GPIO_ARB_TIMEOUT_EN
    logic [7:0] to_cnt_r;

    assign to_hit_s = own_s && (to_cnt_r == 8'(TIMEOUT));

    // Watchdog: cleared while idle (hence on every new grant) or on ack, counts unanswered strobes.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_cnt_r <= 8'd0;
        end else if (!own_s || wbs_ack_i || to_hit_s) begin
            to_cnt_r <= 8'd0;
        end else if (wbs_stb_o) begin
            to_cnt_r <= to_cnt_r + 8'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign to_hit_s = 1'b0;
`endif

    // Next-state: grant from IDLE, release (always via one IDLE bubble) when the owner drops cyc.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        gidx_nxt_s  = gidx_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (rr_valid_s) begin
                    state_nxt_s = OWN;
                    grant_nxt_s = rr_gnt_s;
                    gidx_nxt_s  = rr_idx_s;
                end else begin
                    grant_nxt_s = '0;
                end
            end
            OWN: begin
                if (!wbm_cyc_i[gidx_r] || to_hit_s) begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                    ptr_nxt_s   = (gidx_r == IW'(N - 1)) ? IW'(0) : gidx_r + IW'(1);
                end else begin
                    state_nxt_s = OWN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r <= IDLE;
            grant_r <= '0;
            gidx_r  <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            gidx_r  <= gidx_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Slave-side mux: owner's signals pass straight through, everything is 0 when idle.
    always_comb begin
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_cti_o = 3'b000;
        wbs_bte_o = 2'b00;
        if (own_s) begin
            wbs_cyc_o = wbm_cyc_i[gidx_r] & ~to_hit_s;
            wbs_stb_o = wbm_cyc_i[gidx_r] & wbm_stb_i[gidx_r] & ~to_hit_s;
            wbs_we_o  = wbm_we_i[gidx_r];
            wbs_adr_o = wbm_adr_i[gidx_r*AW +: AW];
            wbs_dat_o = wbm_dat_i[gidx_r*DW +: DW];
            wbs_sel_o = wbm_sel_i[gidx_r*SW +: SW];
            wbs_cti_o = wbm_cti_i[gidx_r*3 +: 3];
            wbs_bte_o = wbm_bte_i[gidx_r*2 +: 2];
        end else begin
            wbs_cyc_o = 1'b0;
        end
    end

    // Ack/err go to the owner only; responses after the owner drops cyc are discarded.
    always_comb begin
        wbm_ack_o = '0;
        wbm_err_o = '0;
        if (own_s) begin
            wbm_ack_o[gidx_r] = wbs_ack_i & wbs_cyc_o;
            wbm_err_o[gidx_r] = (wbs_err_i & wbs_cyc_o) | to_hit_s;
        end else begin
            wbm_ack_o = '0;
        end
    end

endmodule
